// File: rtl/id_stage_ctrl_pkg.sv
// Shared decode definitions for the ID stage controller: RV32I base opcodes,
// the controller state type, the NOP encoding and register-usage helpers.
package id_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FLUSH
    } id_state_e;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_REG: uses_rs1 = 1'b1;
            default:                                               uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        case (opcode)
            OP_STORE, OP_BRANCH, OP_REG: uses_rs2 = 1'b1;
            default:                     uses_rs2 = 1'b0;
        endcase
    endfunction

    function automatic logic is_base_opcode(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
            OP_IMM, OP_REG, OP_LUI, OP_AUIPC: is_base_opcode = 1'b1;
            default:                          is_base_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_ctrl_imm_extract.sv
// Combinational RV32I immediate decoder; R-type and unrecognised opcodes give zero.
module id_imm_extract
    import id_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [31:0] o_imm
);

    always_comb begin
        o_imm = '0;
        case (i_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR:
                o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            OP_STORE:
                o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            OP_BRANCH:
                o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
            OP_JAL:
                o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
            OP_LUI, OP_AUIPC:
                o_imm = {i_instr[31:12], 12'b0};
            default:
                o_imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// IF/ID pipeline register with valid/ready handshakes, load-use bubbles and flush.
// Optional illegal-instruction flag is built when ID_ILLEGAL_TRAP_EN is defined.
module id_stage_ctrl
    import id_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int LOAD_USE_STALL = 1
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid_i,
    input  logic [31:0]     if_instr_i,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            if_ready_o,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [31:0]     id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [31:0]     id_imm_o,
    input  logic            ex_mem_read_i,
    input  logic [4:0]      ex_rd_i,
    input  logic            flush_i,
    output logic [7:0]      stall_cnt_o
`ifdef ID_ILLEGAL_TRAP_EN
    ,
    output logic            id_illegal_o
`endif
);

    localparam logic [1:0] CNT_LOAD = 2'(LOAD_USE_STALL - 1);

    id_state_e       r_state;
    id_state_e       w_stateNext;
    logic [1:0]      r_cnt;
    logic [1:0]      w_cntNext;
    logic            r_full;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc;
    logic [7:0]      r_stallCnt;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic            w_illegal;
    logic            w_srcMatch;
    logic            w_hazard;
    logic            w_ifFire;
    logic            w_idFire;
    logic            w_bubble;

    assign w_opcode = r_instr[6:0];
    assign w_rs1    = r_instr[19:15];
    assign w_rs2    = r_instr[24:20];

`ifdef ID_ILLEGAL_TRAP_EN
    assign w_illegal = !is_base_opcode(w_opcode) || (r_instr[1:0] != 2'b11);
`else
    assign w_illegal = 1'b0;
`endif

    // Only sources the opcode actually reads can collide with the load in EX.
    always_comb begin
        w_srcMatch = (uses_rs1(w_opcode) && (w_rs1 == ex_rd_i)) ||
                     (uses_rs2(w_opcode) && (w_rs2 == ex_rd_i));
        w_hazard   = r_full && ex_mem_read_i && (ex_rd_i != 5'd0) &&
                     w_srcMatch && !w_illegal;
    end

    assign id_valid_o = (r_state == RUN) && r_full && !w_hazard;
    assign if_ready_o = (!r_full || (id_ready_i && id_valid_o)) &&
                        (r_state == RUN) && !w_hazard;
    assign w_idFire   = id_valid_o && id_ready_i;
    assign w_ifFire   = if_valid_i && if_ready_o;
    // The detection cycle already shows a bubble, so it counts alongside STALL cycles.
    assign w_bubble   = ((r_state == RUN) && w_hazard) || (r_state == STALL);

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        if (flush_i) begin
            w_stateNext = FLUSH;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_hazard) begin
                        w_stateNext = STALL;
                        w_cntNext   = CNT_LOAD;
                    end
                end
                STALL: begin
                    w_cntNext = (r_cnt == 2'd0) ? 2'd0 : r_cnt - 2'd1;
                    if (r_cnt <= 2'd1) begin
                        w_stateNext = RUN;
                    end
                end
                FLUSH:   w_stateNext = RUN;
                default: w_stateNext = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // A flush kills any beat that would have been captured on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full  <= 1'b0;
            r_instr <= NOP;
            r_pc    <= '0;
        end else if (flush_i) begin
            r_full  <= 1'b0;
            r_instr <= NOP;
        end else if (w_ifFire) begin
            r_full  <= 1'b1;
            r_instr <= if_instr_i;
            r_pc    <= if_pc_i;
        end else if (w_idFire) begin
            r_full  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCnt <= 8'd0;
        end else if (w_bubble && (r_stallCnt != 8'hFF)) begin
            r_stallCnt <= r_stallCnt + 8'd1;
        end
    end

    assign id_instr_o  = r_full ? r_instr : NOP;
    assign id_pc_o     = r_full ? r_pc : '0;
    assign stall_cnt_o = r_stallCnt;

`ifdef ID_ILLEGAL_TRAP_EN
    assign id_illegal_o = id_valid_o && w_illegal;
`endif

    id_imm_extract u_immExtract (
        .i_instr (id_instr_o),
        .o_imm   (id_imm_o)
    );

endmodule
